// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit holding the MIPS HI/LO pair.
// One shift-add (multiply) or restoring shift-subtract (divide) step per cycle, N steps per op.
module mult_div_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         wr_hi,
  input  logic         wr_lo,
  input  logic [N-1:0] wr_data,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]     r_state;
  logic [CW-1:0]  r_cnt;
  logic [2*N-1:0] r_acc;
  logic [N-1:0]   r_opnd;
  logic [N-1:0]   r_aRaw;
  logic           r_isDiv;
  logic           r_negRes;
  logic           r_negRem;
  logic           r_bZero;
  logic [N-1:0]   r_hi;
  logic [N-1:0]   r_lo;
  logic           r_done;
  logic           r_dbz;

  logic [N-1:0]   w_absA;
  logic [N-1:0]   w_absB;
  logic [N:0]     w_mulSum;
  logic [2*N-1:0] w_mulNext;
  logic [N:0]     w_remShift;
  logic [N:0]     w_diff;
  logic           w_qBit;
  logic [N-1:0]   w_newRem;
  logic [2*N-1:0] w_divNext;
  logic [2*N-1:0] w_prodFix;
  logic [N-1:0]   w_quotFix;
  logic [N-1:0]   w_remFix;

  assign w_absA = (op[0] && a[N-1]) ? -a : a;
  assign w_absB = (op[0] && b[N-1]) ? -b : b;

  // Multiply: low half of r_acc holds the unconsumed multiplier bits, high half accumulates.
  assign w_mulSum  = {1'b0, r_acc[2*N-1:N]} + (r_acc[0] ? {1'b0, r_opnd} : {(N+1){1'b0}});
  assign w_mulNext = {w_mulSum, r_acc[N-1:1]};

  // Divide: high half is the partial remainder, low half shifts dividend out and quotient in.
  assign w_remShift = {r_acc[2*N-1:N], r_acc[N-1]};
  assign w_diff     = w_remShift - {1'b0, r_opnd};
  assign w_qBit     = ~w_diff[N];
  assign w_newRem   = w_qBit ? w_diff[N-1:0] : w_remShift[N-1:0];
  assign w_divNext  = {w_newRem, r_acc[N-2:0], w_qBit};

  assign w_prodFix = r_negRes ? -r_acc : r_acc;
  assign w_quotFix = r_negRes ? -r_acc[N-1:0] : r_acc[N-1:0];
  assign w_remFix  = r_negRem ? -r_acc[2*N-1:N] : r_acc[2*N-1:N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_aRaw   <= '0;
      r_isDiv  <= 1'b0;
      r_negRes <= 1'b0;
      r_negRem <= 1'b0;
      r_bZero  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (wr_hi) r_hi <= wr_data;
          if (wr_lo) r_lo <= wr_data;
          if (start) begin
            r_isDiv  <= op[1];
            r_negRes <= op[0] & (a[N-1] ^ b[N-1]);
            r_negRem <= op[0] & a[N-1];
            r_bZero  <= (b == '0);
            r_aRaw   <= a;
            r_opnd   <= op[1] ? w_absB : w_absA;
            r_acc    <= {{N{1'b0}}, (op[1] ? w_absA : w_absB)};
            r_cnt    <= '0;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          r_acc <= r_isDiv ? w_divNext : w_mulNext;
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_FIX: begin
          // A zero divisor overrides the iterated result with the architectural fallback values.
          if (r_isDiv && r_bZero) begin
            r_lo <= '1;
            r_hi <= r_aRaw;
          end else if (r_isDiv) begin
            r_lo <= w_quotFix;
            r_hi <= w_remFix;
          end else begin
            r_lo <= w_prodFix[N-1:0];
            r_hi <= w_prodFix[2*N-1:N];
          end
          r_done  <= 1'b1;
          r_dbz   <= r_isDiv & r_bZero;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: a 32-bit and an 8-bit instance share one stimulus stream and are
// compared every cycle against an arithmetic reference with a countdown latency model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        wrHi = 1'b0;
  logic        wrLo = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] wrData = '0;

  logic        busy32, done32, dbz32;
  logic [31:0] hi32, lo32;
  logic        busy8, done8, dbz8;
  logic [7:0]  hi8, lo8;

  int nVec = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.N(32)) dut32 (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .wr_hi(wrHi), .wr_lo(wrLo), .wr_data(wrData),
    .busy(busy32), .done(done32), .div_by_zero(dbz32), .hi(hi32), .lo(lo32)
  );

  mult_div_unit #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a[7:0]), .b(b[7:0]),
    .wr_hi(wrHi), .wr_lo(wrLo), .wr_data(wrData[7:0]),
    .busy(busy8), .done(done8), .div_by_zero(dbz8), .hi(hi8), .lo(lo8)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] msk(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  // Reference result {div_by_zero, hi, lo} straight from signed/unsigned integer arithmetic.
  function automatic logic [64:0] refOp(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y, input int w);
    logic [31:0] m, ux, uy, h, l;
    longint sx, sy, q, r;
    logic [63:0] p;
    logic z;
    m = msk(w);
    ux = x & m;
    uy = y & m;
    sx = longint'({32'b0, ux});
    sy = longint'({32'b0, uy});
    if (o[0] && ux[w-1]) sx = sx - (longint'(1) << w);
    if (o[0] && uy[w-1]) sy = sy - (longint'(1) << w);
    z = 1'b0;
    if (!o[1]) begin
      if (o[0]) p = 64'(sx * sy);
      else      p = {32'b0, ux} * {32'b0, uy};
      l = p[31:0] & m;
      h = 32'(p >> w) & m;
    end else if (uy == 32'd0) begin
      l = m;
      h = ux;
      z = 1'b1;
    end else if (o[0]) begin
      q = sx / sy;
      r = sx % sy;
      l = 32'(q) & m;
      h = 32'(r) & m;
    end else begin
      l = ux / uy;
      h = ux % uy;
    end
    return {z, h, l};
  endfunction

  int          wid[2] = '{32, 8};
  logic [31:0] mHi[2];
  logic [31:0] mLo[2];
  logic        mDone[2];
  logic        mDbz[2];
  int          mLeft[2];
  logic [64:0] mPend[2];

  // Model: an accepted start is busy for width+1 cycles, then the result lands with a done pulse.
  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mHi[k] <= '0;
        mLo[k] <= '0;
        mDone[k] <= 1'b0;
        mDbz[k] <= 1'b0;
        mLeft[k] <= 0;
      end else begin
        mDone[k] <= 1'b0;
        mDbz[k] <= 1'b0;
        if (mLeft[k] != 0) begin
          mLeft[k] <= mLeft[k] - 1;
          if (mLeft[k] == 1) begin
            mLo[k] <= mPend[k][31:0];
            mHi[k] <= mPend[k][63:32];
            mDbz[k] <= mPend[k][64];
            mDone[k] <= 1'b1;
          end
        end else begin
          if (wrHi) mHi[k] <= wrData & msk(wid[k]);
          if (wrLo) mLo[k] <= wrData & msk(wid[k]);
          if (start) begin
            mLeft[k] <= wid[k] + 1;
            mPend[k] <= refOp(op, a, b, wid[k]);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("busy%0d", wid[k]), {31'b0, (k == 0) ? busy32 : busy8},
                  {31'b0, mLeft[k] != 0});
      checkOutput($sformatf("done%0d", wid[k]), {31'b0, (k == 0) ? done32 : done8},
                  {31'b0, mDone[k]});
      checkOutput($sformatf("dbz%0d", wid[k]), {31'b0, (k == 0) ? dbz32 : dbz8},
                  {31'b0, mDbz[k]});
      checkOutput($sformatf("hi%0d", wid[k]), (k == 0) ? hi32 : {24'b0, hi8}, mHi[k]);
      checkOutput($sformatf("lo%0d", wid[k]), (k == 0) ? lo32 : {24'b0, lo8}, mLo[k]);
    end
  end

  // Launch one op once the 32-bit unit is idle and run until its done pulse (sampled at negedges).
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                               input logic wh, input logic wl, input logic [31:0] wd,
                               input logic noise, output int lat, output int lat8, output int bc);
    int guard;
    guard = 0;
    while (busy32 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("idle wait", {31'b0, busy32}, 32'd0);
    start = 1'b1; op = o; a = x; b = y;
    wrHi = wh; wrLo = wl; wrData = wd;
    @(negedge clk);
    start = 1'b0; wrHi = 1'b0; wrLo = 1'b0;
    lat = 0; lat8 = -1; bc = 0;
    while (!done32 && lat < 100) begin
      if (busy32) bc++;
      if (done8 && lat8 < 0) lat8 = lat;
      if (noise && lat == 5) begin
        start = 1'b1; op = 2'b00; a = 32'd1; b = 32'd1;
        wrHi = 1'b1; wrLo = 1'b1; wrData = 32'hDEAD_BEEF;
      end
      if (lat == 6) begin
        start = 1'b0; wrHi = 1'b0; wrLo = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    checkOutput("done timeout", {31'b0, done32}, 32'd1);
  endtask

  initial begin
    int lat, lat8, bc;
    logic [1:0] ro;
    logic [31:0] rx, ry;

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", {31'b0, busy32}, 32'd0);
    checkOutput("reset done", {31'b0, done32}, 32'd0);
    checkOutput("reset hi", hi32, 32'd0);
    checkOutput("reset lo", lo32, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0, lat, lat8, bc);
    checkOutput("multu latency", 32'(lat), 32'd33);
    checkOutput("multu busy cycles", 32'(bc), 32'd33);
    checkOutput("multu hi", hi32, 32'hFFFF_FFFE);
    checkOutput("multu lo", lo32, 32'h0000_0001);

    applyStimulus(2'b01, 32'hFFFF_FFFD, 32'd5, 0, 0, 0, 0, lat, lat8, bc);
    checkOutput("mult hi", hi32, 32'hFFFF_FFFF);
    checkOutput("mult lo", lo32, 32'hFFFF_FFF1);

    applyStimulus(2'b11, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 0, lat, lat8, bc);
    checkOutput("div lo", lo32, 32'hFFFF_FFFD);
    checkOutput("div hi", hi32, 32'hFFFF_FFFF);

    applyStimulus(2'b10, 32'd7, 32'd0, 0, 0, 0, 0, lat, lat8, bc);
    checkOutput("divu0 lo", lo32, 32'hFFFF_FFFF);
    checkOutput("divu0 hi", hi32, 32'h0000_0007);
    checkOutput("divu0 flag", {31'b0, dbz32}, 32'd1);
    @(negedge clk);
    checkOutput("divu0 flag clears", {31'b0, dbz32}, 32'd0);

    applyStimulus(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0, lat, lat8, bc);
    checkOutput("divmin lo", lo32, 32'h8000_0000);
    checkOutput("divmin hi", hi32, 32'd0);
    checkOutput("divmin flag", {31'b0, dbz32}, 32'd0);

    applyStimulus(2'b00, 32'd3, 32'd4, 0, 0, 0, 1, lat, lat8, bc);
    checkOutput("ignored hi", hi32, 32'd0);
    checkOutput("ignored lo", lo32, 32'd12);
    repeat (3) begin
      @(negedge clk);
      checkOutput("no queued start", {31'b0, busy32}, 32'd0);
    end

    wrLo = 1'b1; wrData = 32'h1234_5678;
    @(negedge clk);
    wrLo = 1'b0;
    checkOutput("wr_lo lo", lo32, 32'h1234_5678);
    checkOutput("wr_lo hi kept", hi32, 32'd0);

    start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("pre-reset busy", {31'b0, busy32}, 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async rst busy", {31'b0, busy32}, 32'd0);
    checkOutput("async rst done", {31'b0, done32}, 32'd0);
    checkOutput("async rst hi", hi32, 32'd0);
    checkOutput("async rst lo", lo32, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(2'b00, 32'd6, 32'd7, 0, 0, 0, 0, lat, lat8, bc);
    checkOutput("6x7 lo", lo32, 32'd42);
    checkOutput("6x7 hi", hi32, 32'd0);

    applyStimulus(2'b01, 32'h80, 32'h80, 0, 0, 0, 0, lat, lat8, bc);
    checkOutput("n8 latency", 32'(lat8), 32'd9);
    checkOutput("n8 hi", {24'b0, hi8}, 32'h40);
    checkOutput("n8 lo", {24'b0, lo8}, 32'h00);

    applyStimulus(2'b00, 32'd2, 32'd3, 1, 0, 32'hAAAA_5555, 0, lat, lat8, bc);
    checkOutput("start+wr hi", hi32, 32'd0);
    checkOutput("start+wr lo", lo32, 32'd6);

    for (int i = 0; i < 300; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 7))
        0: ry = 32'd0;
        1: begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
        2: ry = $urandom_range(1, 15);
        3: begin rx = 32'h0000_0080; ry = 32'h0000_00FF; end
        default: ;
      endcase
      applyStimulus(ro, rx, ry, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    $urandom, ($urandom_range(0, 3) == 0), lat, lat8, bc);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
